// File: rtl/bidir_mem_burst.sv
// Burst memory with a shared bidirectional data bus: write bursts sink op, read bursts drive it.
// Optional per-word even parity when BIDIR_MEM_BURST_PARITY_EN is defined.
module bidir_mem_burst #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    inout  wire  [DATA_W-1:0] op,
    input  logic              par_inv,
    output logic              busy,
    output logic              valid,
    output logic              done,
    output logic              perr
);
    localparam int DEPTH = 1 << ADDR_W;
`ifdef BIDIR_MEM_BURST_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, WR, RD, TURN} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   ptr;
    logic [LEN_W-1:0]    cnt;
    logic [DATA_W-1:0]   rdata;
    logic                ld;
    logic [ADDR_W-1:0]   ld_addr;
    logic [MW-1:0]       rword;
    logic [MW-1:0]       mem [DEPTH];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = en ? WR : RD;
            WR:   if (cnt == '0) state_nx = IDLE;
            RD:   if (cnt == '0) state_nx = TURN;
            TURN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A read word is fetched on the accepting edge and on every RD edge with beats left.
    assign ld      = (state == IDLE && start && !en) || (state == RD && cnt != '0);
    assign ld_addr = (state == IDLE) ? addr : ptr;
    assign rword   = mem[ld_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            rdata <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            valid <= ld;
            done  <= (state == WR || state == RD) && cnt == '0;
            if (ld) rdata <= rword[DATA_W-1:0];
            case (state)
                IDLE: if (start) begin
                    ptr <= en ? addr : addr + ADDR_W'(1);
                    cnt <= len;
                end
                WR: if (cnt != '0) begin
                    ptr <= ptr + ADDR_W'(1);
                    cnt <= cnt - LEN_W'(1);
                end
                RD: if (cnt != '0) begin
                    ptr <= ptr + ADDR_W'(1);
                    cnt <= cnt - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Storage is never cleared; reset only blocks the write on its own edge.
    always_ff @(posedge clk) begin
        if (!rst && state == WR) begin
`ifdef BIDIR_MEM_BURST_PARITY_EN
            mem[ptr] <= {(^op) ^ par_inv, op};
`else
            mem[ptr] <= op;
`endif
        end
    end

`ifdef BIDIR_MEM_BURST_PARITY_EN
    logic perr_q;
    // Stored bit equals data parity when intact, so the XOR of the whole word flags a mismatch.
    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= ld ? ^rword : 1'b0;
    end
    assign perr = perr_q;
`else
    logic unused_par;
    assign unused_par = par_inv;
    assign perr = 1'b0;
`endif

    assign busy = (state != IDLE);
    assign op   = (state == RD) ? rdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_bidir_mem_burst.sv
// Directed bench for bidir_mem_burst: bursts, wrap, ignored start, mid-burst reset, parity.
module tb_bidir_mem_burst;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, en = 1'b0, par_inv = 1'b0;
    logic [3:0]  addr = '0, len = '0;
    logic [15:0] op_drv = '0;
    logic        op_oe = 1'b0;
    wire  [15:0] op;
    logic        busy, valid, done, perr;

    int total = 0, bad = 0;
    logic [15:0] wdata [16];
    logic [15:0] mem_m [16];
    bit          par_m [16];

    assign op = op_oe ? op_drv : 16'hzzzz;

    bidir_mem_burst dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .addr(addr), .len(len),
        .op(op), .par_inv(par_inv), .busy(busy), .valid(valid), .done(done), .perr(perr)
    );

    always #5 clk = ~clk;

    // Drive a known pattern; it only reads back intact if the DUT has released the bus.
    task automatic chk_release(input string nm);
        op_oe = 1'b1; op_drv = 16'hC35A;
        #1;
        total++;
        if (op !== 16'hC35A) begin bad++; $display("FAIL %s bus_release got=%h exp=c35a", nm, op); end
        op_oe = 1'b0;
    endtask

    // Tasks start and end right after a negedge.
    task automatic wr(input int a, input int l, input bit pinv);
        start = 1; en = 1; addr = 4'(a); len = 4'(l); par_inv = pinv;
        @(negedge clk);
        start = 0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
        for (int i = 0; i <= l; i++) begin
            op_oe = 1; op_drv = wdata[i];
            mem_m[(a + i) % 16] = wdata[i];
            par_m[(a + i) % 16] = pinv;
            @(negedge clk);
            if (i < l) begin
                total++;
                if (done !== 1'b0) begin bad++; $display("FAIL wr_done_early beat=%0d got=%b exp=0", i, done); end
            end
        end
        op_oe = 0; par_inv = 0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL wr_end done=%b busy=%b exp done=1 busy=0", done, busy); end
    endtask

    task automatic rd(input int a, input int l);
        logic [15:0] e;
        bit          ep;
        start = 1; en = 0; addr = 4'(a); len = 4'(l);
        @(negedge clk);
        start = 0;
        for (int i = 0; i <= l; i++) begin
            e = mem_m[(a + i) % 16];
`ifdef BIDIR_MEM_BURST_PARITY_EN
            ep = par_m[(a + i) % 16];
`else
            ep = 1'b0;
`endif
            total++;
            if (op !== e || valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || perr !== ep) begin
                bad++;
                $display("FAIL rd a=%0d beat=%0d op=%h valid=%b busy=%b done=%b perr=%b exp op=%h valid=1 busy=1 done=0 perr=%b",
                         a, i, op, valid, busy, done, perr, e, ep);
            end
            @(negedge clk);
        end
        total++;
        if (valid !== 1'b0 || busy !== 1'b1 || done !== 1'b1)
            begin bad++; $display("FAIL rd_turn valid=%b busy=%b done=%b exp 0 1 1", valid, busy, done); end
        chk_release("rd_turn");
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL rd_idle busy=%b done=%b exp 0 0", busy, done); end
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk); @(negedge clk);
        total++;
        if (busy !== 0 || valid !== 0 || done !== 0 || perr !== 0)
            begin bad++; $display("FAIL reset busy=%b valid=%b done=%b perr=%b exp 0000", busy, valid, done, perr); end
        chk_release("reset");
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) wdata[i] = 16'(i);
        wr(0, 15, 0);
        rd(0, 15);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) wdata[i] = 16'hA1 + 16'(i);
        wr(14, 3, 0);
        rd(14, 3);
        rd(0, 1);   // A3, A4 must have wrapped into words 0 and 1
    endtask

    task automatic test_ignore();
        start = 1; en = 1; addr = 4'd8; len = 4'd3;
        @(negedge clk);
        start = 0;
        for (int i = 0; i <= 3; i++) begin
            op_oe = 1; op_drv = 16'hB0 + 16'(i);
            mem_m[8 + i] = op_drv; par_m[8 + i] = 0;
            if (i == 1) begin start = 1; en = 0; addr = 4'd5; len = 4'd0; end
            if (i == 3) start = 0;
            @(negedge clk);
            total++;
            if (busy !== (i < 3)) begin bad++; $display("FAIL ign_busy beat=%0d got=%b exp=%b", i, busy, i < 3); end
        end
        op_oe = 0;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL ign_done got=%b exp=1", done); end
        rd(8, 3);
        rd(5, 0);
    endtask

    task automatic test_rst_mid();
        start = 1; en = 1; addr = 4'd8; len = 4'd7;
        @(negedge clk);
        start = 0;
        op_oe = 1; op_drv = 16'hC0; @(negedge clk);
        op_drv = 16'hC1; @(negedge clk);
        op_drv = 16'hC2; rst = 1; @(negedge clk);
        mem_m[8] = 16'hC0; mem_m[9] = 16'hC1; par_m[8] = 0; par_m[9] = 0;
        rst = 0; op_oe = 0;
        total++;
        if (busy !== 0 || done !== 0 || valid !== 0)
            begin bad++; $display("FAIL rstmid busy=%b done=%b valid=%b exp 000", busy, done, valid); end
        chk_release("rstmid");
        rd(8, 7);
    endtask

    task automatic test_back_to_back();
        wdata[0] = 16'h1234; wdata[1] = 16'hFEDC;
        wr(2, 1, 0);
        rd(2, 1);
        wdata[0] = 16'h0F0F;
        wr(2, 0, 0);
        rd(2, 1);
    endtask

    task automatic test_parity();
        wdata[0] = 16'h00FF;
        wr(3, 0, 1);
        rd(3, 0);
        wr(3, 0, 0);
        rd(3, 0);
    endtask

    initial begin
        test_reset();
        test_full();
        test_wrap();
        test_ignore();
        test_rst_mid();
        test_back_to_back();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bidir_mem_burst.md
BIDIR_MEM_BURST -- requirements
Module: bidir_mem_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each word and of the bus.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter LEN_W, default 4, width of burst length field; beats per burst = len+1.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, transaction request, sampled only in IDLE.
REQ-007 SHALL have port en, input, 1, direction at start: 1 = write burst, 0 = read burst.
REQ-008 SHALL have port addr, input, ADDR_W, burst start address, sampled with start.
REQ-009 SHALL have port len, input, LEN_W, burst length minus one, sampled with start.
REQ-010 SHALL have port op, inout, DATA_W, bidirectional data bus; master drives on writes, block drives on reads.
REQ-011 SHALL have port par_inv, input, 1, inverts stored parity on write beats; parity-test hook.
REQ-012 SHALL have ports busy, valid, done, perr, all output, 1: not-IDLE flag, read word on op, one-cycle end-of-burst pulse, parity error flag.

Function
REQ-013 SHALL implement FSM states IDLE, WR, RD, TURN.
REQ-014 SHALL, in IDLE with start=1 at edge N, latch addr into pointer, len into beat counter, go WR if en=1 else RD; start=0 keeps IDLE.
REQ-015 SHALL, in WR, write op into mem[pointer] on each edge N+1..N+len+1; pointer +1 per beat, counter -1 per beat.
REQ-016 SHALL return from WR to IDLE on the edge storing the last beat; start is accepted on the following edge.
REQ-017 SHALL, on entering RD at edge N, register mem[addr] onto op with output enable and valid high during cycle N..N+1 (one-cycle latency); each later edge loads next word until len+1 words presented.
REQ-018 SHALL go RD -> TURN after the last word; TURN lasts exactly one cycle with op released to high-Z, then IDLE.
REQ-019 SHALL hold op at high-Z whenever state is not RD.
REQ-020 SHALL wrap pointer from DEPTH-1 to 0 within a burst (modulo DEPTH).
REQ-021 SHALL ignore start, en, addr, len while busy=1; no queueing.
REQ-022 SHALL assert busy in WR, RD, TURN; deassert only in IDLE.
REQ-023 SHALL pulse done for exactly one cycle, the cycle after the last write beat or the TURN cycle of a read.
REQ-024 SHALL let a read return data written by any earlier completed write burst, including the immediately preceding one.

Reset
REQ-025 SHALL on rst=1 at any edge, including mid-burst, force IDLE, op high-Z, busy=0, valid=0, done=0, perr=0, pointer=0, counter=0.
REQ-026 SHALL NOT clear memory contents on reset; an interrupted write keeps beats already stored.
REQ-027 SHALL give rst priority over start on the same edge.

Configuration
REQ-028 SHALL, with macro BIDIR_MEM_BURST_PARITY_EN defined, store one extra even-parity bit per word (XOR of data, XOR par_inv) and on each read word set perr = recomputed parity mismatch, registered alongside valid.
REQ-029 SHALL, without BIDIR_MEM_BURST_PARITY_EN, store DATA_W bits only, ignore par_inv, and tie perr to 0.

Verification
REQ-030 Write burst addr=0 len=15 data=i, then read burst addr=0 len=15 -> op=0..15 on consecutive cycles, valid=1 for 16 cycles, done single pulse, then one TURN cycle at Z.
REQ-031 Write addr=14 len=3 data 0xA1..0xA4 -> mem[14]=0xA1, mem[15]=0xA2, mem[0]=0xA3, mem[1]=0xA4; read back addr=14 len=3 matches.
REQ-032 start=1 en=0 addr=5 raised during an active write -> ignored; write completes unchanged, read at 5 shows old value.
REQ-033 rst=1 on third beat of a len=7 write at addr=8 -> IDLE next cycle, op Z, mem[8],mem[9] updated, mem[10..15] unchanged.
REQ-034 With BIDIR_MEM_BURST_PARITY_EN: write 0x00FF par_inv=1 at addr=3, read -> perr=1 with valid; rewrite par_inv=0 -> perr=0; without macro perr=0 always.
